// File: rtl/cordic_iter_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_iter_ctrl -- iterative sequencer around the combinational `cordic`
// micro-rotation stage.
//
// Purpose:
//   Latches an operand set on a start handshake and then runs one
//   micro-rotation per clock. Each cycle the stage outputs are registered
//   back into its inputs, and the shift amount and LUT entry are stepped.
//   Circular mode runs shifts 0..p_ITER-1. Hyperbolic mode runs shifts
//   1..p_ITER-1, and shifts 4 and 13 are executed twice to guarantee
//   convergence. The final vector is presented with a one-cycle done pulse.
//
// Ports (cordic_iter_ctrl):
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset
//   i_start  start request, honoured only in IDLE or DONE
//   i_mode   1 = circular, 0 = hyperbolic
//   i_x/i_y  initial vector (format agnostic, x pre-scaled by 1/K)
//   i_z      initial angle, signed q.31 with full scale = 180 degrees
//   o_busy   high while iterating
//   o_done   one-cycle pulse, o_x/o_y/o_z valid in that cycle
//   o_x/o_y  result vector registers
//   o_z      residual angle register
//
// Ports (cordic stage):
//   i_mode/i_d/i_shift/i_lut  rotation mode, direction, shift and angle step
//   i_x/i_y/i_z -> o_x/o_y/o_z  one micro-rotation, o_d = next direction
// ---------------------------------------------------------------------------

module cordic #(
  parameter int p_WIDTH = 32
) (
  input  logic               i_mode,
  input  logic               i_d,
  input  logic [4:0]         i_shift,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  input  logic [p_WIDTH-1:0] i_lut,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z,
  output logic               o_d
);

  logic [p_WIDTH-1:0] w_xShr;
  logic [p_WIDTH-1:0] w_yShr;
  logic               w_xAddsY;

  // One micro-rotation. Circular mode moves x against y, and hyperbolic mode
  // moves x with y. The next direction is the sign of the new residual angle.
  always_comb begin
    w_xShr   = $signed(i_x) >>> i_shift;
    w_yShr   = $signed(i_y) >>> i_shift;
    w_xAddsY = i_mode ? ~i_d : i_d;
    o_x      = w_xAddsY ? (i_x + w_yShr) : (i_x - w_yShr);
    o_y      = i_d ? (i_y + w_xShr) : (i_y - w_xShr);
    o_z      = i_d ? (i_z - i_lut) : (i_z + i_lut);
    o_d      = ~o_z[p_WIDTH-1];
  end

endmodule

module cordic_iter_ctrl #(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  output logic               o_busy,
  output logic               o_done,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [4:0] c_LAST = 5'(p_ITER - 1);

  state_t             r_state;
  logic [p_WIDTH-1:0] r_x;
  logic [p_WIDTH-1:0] r_y;
  logic [p_WIDTH-1:0] r_z;
  logic               r_d;
  logic [4:0]         r_shift;
  logic               r_rep;
  logic               r_mode;

  logic [p_WIDTH-1:0] w_x;
  logic [p_WIDTH-1:0] w_y;
  logic [p_WIDTH-1:0] w_z;
  logic               w_d;
  logic [31:0]        w_lut32;
  logic [p_WIDTH-1:0] w_lut;
  logic               w_repeatNow;

  // atan(2^-i) as a q.31 angle with full scale = 180 degrees
  function automatic logic [31:0] atanRom(input logic [4:0] idx);
    case (idx)
      5'd0:    atanRom = 32'h20000000;
      5'd1:    atanRom = 32'h12E4051E;
      5'd2:    atanRom = 32'h09FB385B;
      5'd3:    atanRom = 32'h051111D4;
      5'd4:    atanRom = 32'h028B0D43;
      5'd5:    atanRom = 32'h0145D7E1;
      5'd6:    atanRom = 32'h00A2F61E;
      5'd7:    atanRom = 32'h00517C55;
      5'd8:    atanRom = 32'h0028BE53;
      5'd9:    atanRom = 32'h00145F2F;
      5'd10:   atanRom = 32'h000A2F98;
      5'd11:   atanRom = 32'h000517CC;
      5'd12:   atanRom = 32'h00028BE6;
      5'd13:   atanRom = 32'h000145F3;
      5'd14:   atanRom = 32'h0000A2FA;
      5'd15:   atanRom = 32'h0000517D;
      5'd16:   atanRom = 32'h000028BE;
      5'd17:   atanRom = 32'h0000145F;
      5'd18:   atanRom = 32'h00000A30;
      5'd19:   atanRom = 32'h00000518;
      default: atanRom = 32'h00000000;
    endcase
  endfunction

  // atanh(2^-i) in the same angle scaling; entry 0 is never addressed
  function automatic logic [31:0] atanhRom(input logic [4:0] idx);
    case (idx)
      5'd1:    atanhRom = 32'h1661788D;
      5'd2:    atanhRom = 32'h0A680D61;
      5'd3:    atanhRom = 32'h051EA6FD;
      5'd4:    atanhRom = 32'h028CBFDD;
      5'd5:    atanhRom = 32'h01460E34;
      5'd6:    atanhRom = 32'h00A2FCE8;
      5'd7:    atanhRom = 32'h00517D2E;
      5'd8:    atanhRom = 32'h0028BE6E;
      5'd9:    atanhRom = 32'h00145F32;
      5'd10:   atanhRom = 32'h000A2F98;
      5'd11:   atanhRom = 32'h000517CC;
      5'd12:   atanhRom = 32'h00028BE6;
      5'd13:   atanhRom = 32'h000145F3;
      5'd14:   atanhRom = 32'h0000A2FA;
      5'd15:   atanhRom = 32'h0000517D;
      5'd16:   atanhRom = 32'h000028BE;
      5'd17:   atanhRom = 32'h0000145F;
      5'd18:   atanhRom = 32'h00000A30;
      5'd19:   atanhRom = 32'h00000518;
      default: atanhRom = 32'h00000000;
    endcase
  endfunction

  // Zero-latency LUT lookup. A repeat is pending on the first visit to
  // shift 4 or 13 in hyperbolic mode.
  always_comb begin
    w_lut32     = r_mode ? atanRom(r_shift) : atanhRom(r_shift);
    w_repeatNow = ~r_mode & ~r_rep & ((r_shift == 5'd4) | (r_shift == 5'd13));
  end

  // The constants are MSB-aligned, so narrower datapaths keep the top bits.
  assign w_lut = p_WIDTH'({w_lut32, 32'h00000000} >> (64 - p_WIDTH));

  cordic #(
    .p_WIDTH(p_WIDTH)
  ) u_stage (
    .i_mode (r_mode),
    .i_d    (r_d),
    .i_shift(r_shift),
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_lut  (w_lut),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_z    (w_z),
    .o_d    (w_d)
  );

  // Control FSM with registered busy/done flags. DONE lasts one cycle and
  // accepts a new start, which allows back-to-back operations.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_d     <= 1'b1;
      r_shift <= 5'd0;
      r_rep   <= 1'b0;
      r_mode  <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_x     <= i_x;
            r_y     <= i_y;
            r_z     <= i_z;
            r_mode  <= i_mode;
            r_d     <= ~i_z[p_WIDTH-1];
            r_shift <= i_mode ? 5'd0 : 5'd1;
            r_rep   <= 1'b0;
            r_state <= S_RUN;
            o_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_x <= w_x;
          r_y <= w_y;
          r_z <= w_z;
          r_d <= w_d;
          if (w_repeatNow) begin
            r_rep <= 1'b1;
          end else if (r_shift == c_LAST) begin
            r_rep   <= 1'b0;
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_rep   <= 1'b0;
            r_shift <= r_shift + 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
  assign o_z = r_z;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cordic_iter_ctrl -- self-checking bench for cordic_iter_ctrl.
//
// Directed vectors come from a table. Their results are compared with a
// bit-exact integer model of the rotation algorithm and also with the ideal
// real-valued rotation scaled by the iteration gain. Random operations are
// compared with the integer model. Hand-written sequences cover the
// following cases:
//   - reset while start is held
//   - a start request while the block is busy
//   - a relaunch during the DONE cycle
//   - an abort by reset partway through an operation
// ---------------------------------------------------------------------------

module tb_cordic_iter_ctrl;

  localparam int  cWidth   = 32;
  localparam int  cIter    = 20;
  localparam int  cTimeout = 60;
  localparam real cPi      = 3.14159265358979323846;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              i_mode;
  logic [cWidth-1:0] i_x;
  logic [cWidth-1:0] i_y;
  logic [cWidth-1:0] i_z;
  logic              o_busy;
  logic              o_done;
  logic [cWidth-1:0] o_x;
  logic [cWidth-1:0] o_y;
  logic [cWidth-1:0] o_z;

  int nPass  = 0;
  int nTotal = 0;

  typedef struct {
    string name;
    bit    mode;
    int    x0;
    int    y0;
    int    z0;
    int    expCycles;
    int    expX;
    int    expY;
    int    tol;
  } vec_t;

  vec_t vecs[6];

  cordic_iter_ctrl #(
    .p_WIDTH(cWidth),
    .p_ITER (cIter)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_mode (i_mode),
    .i_x    (i_x),
    .i_y    (i_y),
    .i_z    (i_z),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_x    (o_x),
    .o_y    (o_y),
    .o_z    (o_z)
  );

  // Free-running clock with a 10-unit period
  always #5 i_clk = ~i_clk;

  // Stops the run if the main sequence stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", nPass, nTotal);
    $fatal(1, "[TB] watchdog expired");
  end

  // Moves just past a rising edge. All driving and sampling happens here.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic checkNear(input string name, input int act, input int exp, input int tol);
    longint diff;
    diff = longint'(act) - longint'(exp);
    if (diff < 0) diff = -diff;
    nTotal++;
    if (diff <= longint'(tol)) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d within %0d", name, act, exp, tol);
  endtask

  // Standard angle constants: atan/atanh(2^-s) scaled so that 2^31 = 180 degrees
  function automatic int lutAngle(input bit circular, input int s);
    int atanTab[20] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43,
      32'h0145D7E1, 32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F,
      32'h000A2F98, 32'h000517CC, 32'h00028BE6, 32'h000145F3, 32'h0000A2FA,
      32'h0000517D, 32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518};
    int atanhTab[20] = '{
      32'h00000000, 32'h1661788D, 32'h0A680D61, 32'h051EA6FD, 32'h028CBFDD,
      32'h01460E34, 32'h00A2FCE8, 32'h00517D2E, 32'h0028BE6E, 32'h00145F32,
      32'h000A2F98, 32'h000517CC, 32'h00028BE6, 32'h000145F3, 32'h0000A2FA,
      32'h0000517D, 32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518};
    return circular ? atanTab[s] : atanhTab[s];
  endfunction

  // Reference model of the algorithm. It builds the shift schedule as a
  // queue, rotates by sigma = sign(z) at each step with wrapping 32-bit
  // integers, and accumulates the ideal gain of the schedule.
  task automatic refModel(input bit circular, input int x0, input int y0, input int z0,
                          output int xr, output int yr, output int zr,
                          output int nSteps, output real gain);
    int sh[$];
    int x, y, z, xs, ys, xNew, sigma, m;
    gain = 1.0;
    if (circular) begin
      for (int s = 0; s < cIter; s++) sh.push_back(s);
    end else begin
      for (int s = 1; s < cIter; s++) begin
        sh.push_back(s);
        if (s == 4 || s == 13) sh.push_back(s);
      end
    end
    m = circular ? 1 : -1;
    x = x0;
    y = y0;
    z = z0;
    foreach (sh[k]) begin
      sigma = (z >= 0) ? 1 : -1;
      xs    = x >>> sh[k];
      ys    = y >>> sh[k];
      xNew  = x - m * sigma * ys;
      y     = y + sigma * xs;
      x     = xNew;
      z     = z - sigma * lutAngle(circular, sh[k]);
      gain  = gain * $sqrt(1.0 + real'(m) * $pow(2.0, -2.0 * real'(sh[k])));
    end
    xr     = x;
    yr     = y;
    zr     = z;
    nSteps = sh.size();
  endtask

  task automatic applyStimulus(input bit mode, input int x0, input int y0, input int z0);
    i_mode  = mode;
    i_x     = x0;
    i_y     = y0;
    i_z     = z0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Counts cycles from the start edge to the done pulse, with a bounded wait
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (o_done !== 1'b1 && cycles < cTimeout) begin
      tick();
      cycles++;
    end
  endtask

  // Runs one operation and checks its latency, exact results, pulse width
  // and result hold
  task automatic runOp(input string name, input bit mode, input int x0, input int y0,
                       input int z0, input int expCycles);
    int  ex, ey, ez, n, cycles;
    real g;
    refModel(mode, x0, y0, z0, ex, ey, ez, n, g);
    applyStimulus(mode, x0, y0, z0);
    checkOutput({name, "_busy"}, o_busy, 1'b1);
    waitDone(cycles);
    checkOutput({name, "_latency"}, cycles, expCycles);
    checkOutput({name, "_x"}, o_x, ex);
    checkOutput({name, "_y"}, o_y, ey);
    checkOutput({name, "_z"}, o_z, ez);
    tick();
    checkOutput({name, "_pulse"}, {o_busy, o_done}, 2'b00);
    checkOutput({name, "_hold_x"}, o_x, ex);
  endtask

  task automatic setVec(input int idx, input string name, input bit mode, input int x0,
                        input int z0, input int expCycles, input int tol);
    vecs[idx].name      = name;
    vecs[idx].mode      = mode;
    vecs[idx].x0        = x0;
    vecs[idx].y0        = 0;
    vecs[idx].z0        = z0;
    vecs[idx].expCycles = expCycles;
    vecs[idx].expX      = 0;
    vecs[idx].expY      = 0;
    vecs[idx].tol       = tol;
  endtask

  initial begin
    int  ex1, ey1, ez1, ex2, ey2, ez2, n, cycles, doneSeen, ex, ey, ez;
    real g, th, rx, ry;

    // Directed vectors. Circular x is q1.31 and hyperbolic x is q3.28.
    setVec(0, "circ_p30",  1'b1, 32'h4DBA76D5, 32'h15555555, 20, 32768);
    setVec(1, "hyp_p10",   1'b0, 32'h13483D0E, 32'h071C71C7, 21, 16384);
    setVec(2, "circ_m30",  1'b1, 32'h4DBA76D5, 32'hEAAAAAAB, 20, 32768);
    setVec(3, "circ_m45",  1'b1, 32'h4DBA76D5, 32'hE0000000, 20, 32768);
    setVec(4, "circ_p60",  1'b1, 32'h4DBA76D5, 32'h2AAAAAAB, 20, 32768);
    setVec(5, "hyp_m10",   1'b0, 32'h13483D0E, 32'hF8E38E39, 21, 16384);

    // Expected vector is the ideal rotation times the schedule gain
    foreach (vecs[i]) begin
      refModel(vecs[i].mode, vecs[i].x0, vecs[i].y0, vecs[i].z0, ex, ey, ez, n, g);
      th = real'(vecs[i].z0) / 2147483648.0 * cPi;
      if (vecs[i].mode) begin
        rx = g * (real'(vecs[i].x0) * $cos(th) - real'(vecs[i].y0) * $sin(th));
        ry = g * (real'(vecs[i].y0) * $cos(th) + real'(vecs[i].x0) * $sin(th));
      end else begin
        rx = g * (real'(vecs[i].x0) * $cosh(th) + real'(vecs[i].y0) * $sinh(th));
        ry = g * (real'(vecs[i].y0) * $cosh(th) + real'(vecs[i].x0) * $sinh(th));
      end
      vecs[i].expX = int'(rx);
      vecs[i].expY = int'(ry);
    end

    // Reset while start is held high
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_mode  = 1'b1;
    i_x     = 32'h12345678;
    i_y     = 32'h0BADBEEF;
    i_z     = 32'h15555555;
    repeat (3) tick();
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_done", o_done, 1'b0);
    checkOutput("rst_x", o_x, 32'h0);
    checkOutput("rst_y", o_y, 32'h0);
    checkOutput("rst_z", o_z, 32'h0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    tick();
    checkOutput("idle_after_rst", {o_busy, o_done}, 2'b00);

    // Table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      runOp(vecs[i].name, vecs[i].mode, vecs[i].x0, vecs[i].y0, vecs[i].z0, vecs[i].expCycles);
      checkNear({vecs[i].name, "_approx_x"}, o_x, vecs[i].expX, vecs[i].tol);
      checkNear({vecs[i].name, "_approx_y"}, o_y, vecs[i].expY, vecs[i].tol);
      checkNear({vecs[i].name, "_resid_z"}, o_z, 0, 32'h00001000);
    end

    // Randomized operations compared with the integer model
    for (int r = 0; r < 12; r++) begin
      bit rMode;
      rMode = 1'($urandom_range(0, 1));
      runOp($sformatf("rand%0d", r), rMode, int'($urandom), int'($urandom), int'($urandom),
            rMode ? cIter : cIter + 1);
    end

    // A start while busy is ignored, and a start in the DONE cycle relaunches
    refModel(1'b1, 32'h4DBA76D5, 0, 32'h15555555, ex1, ey1, ez1, n, g);
    refModel(1'b1, 32'h4DBA76D5, 0, 32'hE0000000, ex2, ey2, ez2, n, g);
    applyStimulus(1'b1, 32'h4DBA76D5, 0, 32'h15555555);
    cycles = 0;
    while (o_done !== 1'b1 && cycles < cTimeout) begin
      if (cycles == 5) begin
        i_start = 1'b1;
        i_mode  = 1'b0;
        i_x     = 32'h7FFFFFFF;
        i_z     = 32'h40000000;
      end else begin
        i_start = 1'b0;
      end
      tick();
      cycles++;
    end
    i_start = 1'b0;
    checkOutput("busy_start_latency", cycles, 20);
    checkOutput("busy_start_x", o_x, ex1);
    checkOutput("busy_start_y", o_y, ey1);
    checkOutput("busy_start_z", o_z, ez1);
    i_mode  = 1'b1;
    i_x     = 32'h4DBA76D5;
    i_y     = 32'h0;
    i_z     = 32'hE0000000;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checkOutput("relaunch_busy", {o_busy, o_done}, 2'b10);
    waitDone(cycles);
    checkOutput("relaunch_latency", cycles, 20);
    checkOutput("relaunch_x", o_x, ex2);
    checkOutput("relaunch_y", o_y, ey2);
    checkOutput("relaunch_z", o_z, ez2);
    tick();

    // Reset after seven iterations aborts with no done pulse
    applyStimulus(1'b0, 32'h13483D0E, 0, 32'h071C71C7);
    repeat (7) tick();
    checkOutput("abort_busy_before", o_busy, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkOutput("abort_flags", {o_busy, o_done}, 2'b00);
    checkOutput("abort_x", o_x, 32'h0);
    checkOutput("abort_y", o_y, 32'h0);
    checkOutput("abort_z", o_z, 32'h0);
    doneSeen = 0;
    repeat (30) begin
      tick();
      if (o_done === 1'b1 || o_busy === 1'b1) doneSeen++;
    end
    checkOutput("abort_stays_idle", doneSeen, 0);
    runOp("after_abort", vecs[4].mode, vecs[4].x0, vecs[4].y0, vecs[4].z0, 20);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
